// File: rtl/ram8_rr_arbiter_if.sv
// Client and RAM-side signal bundle for the two-client RAM arbiter.
// The arbiter uses the slave view; the client/RAM environment uses the master view.
interface ram8_rr_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  // client 0
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  // client 1
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  // shared status
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [1:0]        grant;
  // RAM control pins
  logic              ram_en;
  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_add;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_out,
    output ack0, ack1, rdata, busy, grant,
    output ram_en, ram_read, ram_write, ram_add, ram_in
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_out,
    input  ack0, ack1, rdata, busy, grant,
    input  ram_en, ram_read, ram_write, ram_add, ram_in
  );
endinterface

// File: rtl/ram8_rr_arbiter.sv
// Two-client round-robin arbiter/sequencer for the 8x16 register-file RAM.
// One transaction in flight: IDLE -> ACCESS -> RESP, all outputs registered.
module ram8_rr_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input logic                 clk,
  input logic                 rst,
  ram8_rr_arbiter_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state,     state_nxt;
  logic              prio,      prio_nxt;
  logic              lat_we,    lat_we_nxt;
  logic [1:0]        grant,     grant_nxt;
  logic              ack0,      ack0_nxt;
  logic              ack1,      ack1_nxt;
  logic              busy,      busy_nxt;
  logic [DATA_W-1:0] rdata,     rdata_nxt;
  logic              ram_en,    ram_en_nxt;
  logic              ram_read,  ram_read_nxt;
  logic              ram_write, ram_write_nxt;
  logic [ADDR_W-1:0] ram_add,   ram_add_nxt;
  logic [DATA_W-1:0] ram_in,    ram_in_nxt;
  logic              sel;

  // State and output registers; reset kills any in-flight RAM strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      prio      <= 1'b0;
      lat_we    <= 1'b0;
      grant     <= 2'b00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      ram_en    <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_add   <= '0;
      ram_in    <= '0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      lat_we    <= lat_we_nxt;
      grant     <= grant_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      busy      <= busy_nxt;
      rdata     <= rdata_nxt;
      ram_en    <= ram_en_nxt;
      ram_read  <= ram_read_nxt;
      ram_write <= ram_write_nxt;
      ram_add   <= ram_add_nxt;
      ram_in    <= ram_in_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    prio_nxt      = prio;
    lat_we_nxt    = lat_we;
    grant_nxt     = grant;
    ack0_nxt      = 1'b0;
    ack1_nxt      = 1'b0;
    busy_nxt      = busy;
    rdata_nxt     = rdata;
    ram_en_nxt    = 1'b0;
    ram_read_nxt  = 1'b0;
    ram_write_nxt = 1'b0;
    ram_add_nxt   = '0;
    ram_in_nxt    = '0;
    sel           = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // prio only matters on contention; otherwise the lone requester wins
          sel        = (bus.req0 && bus.req1) ? prio : bus.req1;
          lat_we_nxt = sel ? bus.we1 : bus.we0;
          grant_nxt  = sel ? 2'b10 : 2'b01;
          busy_nxt   = 1'b1;
          state_nxt  = S_ACCESS;
          // The ram_* registers double as the latched address/data copies
          ram_en_nxt    = 1'b1;
          ram_write_nxt = lat_we_nxt;
          ram_read_nxt  = !lat_we_nxt;
          ram_add_nxt   = sel ? bus.addr1 : bus.addr0;
          if (lat_we_nxt) begin
            ram_in_nxt = sel ? bus.wdata1 : bus.wdata0;
          end
        end else begin
          grant_nxt = 2'b00;
          busy_nxt  = 1'b0;
        end
      end
      S_ACCESS: begin
        state_nxt = S_RESP;
        if (!lat_we) begin
          rdata_nxt = bus.ram_out;
        end
        ack0_nxt = grant[0];
        ack1_nxt = grant[1];
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        prio_nxt  = grant[0];
        grant_nxt = 2'b00;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = 2'b00;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.rdata     = rdata;
  assign bus.busy      = busy;
  assign bus.grant     = grant;
  assign bus.ram_en    = ram_en;
  assign bus.ram_read  = ram_read;
  assign bus.ram_write = ram_write;
  assign bus.ram_add   = ram_add;
  assign bus.ram_in    = ram_in;

endmodule

// File: tb/tb_ram8_rr_arbiter.sv
// Bench for ram8_rr_arbiter: behavioural RAM, transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ram8_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  ram8_rr_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  ram8_rr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Behavioural RAM attached to the arbiter's RAM pins
  logic [15:0] ram_mem [8];
  always @(posedge clk) if (bus.ram_en && bus.ram_write) ram_mem[bus.ram_add] <= bus.ram_in;
  assign bus.ram_out = ram_mem[bus.ram_add];

  // Reference model: who owns the RAM, how many cycles since the grant,
  // and a shadow copy of memory contents at transaction level.
  int          m_age;   // -1: nobody granted; 0: access cycle; 1: ack cycle
  int          m_who;
  int          m_prio;
  logic        m_we;
  logic [2:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic [15:0] m_mem [8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = -1; m_prio = 0; m_rdata = 16'h0; m_who = 0;
    end else if (m_age < 0) begin
      if (bus.req0 || bus.req1) begin
        m_who   = (bus.req0 && bus.req1) ? m_prio : (bus.req1 ? 1 : 0);
        m_we    = (m_who == 1) ? bus.we1    : bus.we0;
        m_addr  = (m_who == 1) ? bus.addr1  : bus.addr0;
        m_wdata = (m_who == 1) ? bus.wdata1 : bus.wdata0;
        m_age   = 0;
      end
    end else if (m_age == 0) begin
      if (m_we) m_mem[m_addr] = m_wdata;
      else      m_rdata = m_mem[m_addr];
      m_age = 1;
    end else begin
      m_prio = 1 - m_who;
      m_age  = -1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic acc;
    acc = (m_age == 0);
    chk("busy",      32'(bus.busy),      32'(m_age >= 0));
    chk("grant",     32'(bus.grant),     (m_age >= 0) ? ((m_who == 1) ? 32'd2 : 32'd1) : 32'd0);
    chk("ack0",      32'(bus.ack0),      32'(m_age == 1 && m_who == 0));
    chk("ack1",      32'(bus.ack1),      32'(m_age == 1 && m_who == 1));
    chk("rdata",     32'(bus.rdata),     32'(m_rdata));
    chk("ram_en",    32'(bus.ram_en),    32'(acc));
    chk("ram_write", 32'(bus.ram_write), 32'(acc && m_we));
    chk("ram_read",  32'(bus.ram_read),  32'(acc && !m_we));
    chk("ram_add",   32'(bus.ram_add),   acc ? 32'(m_addr) : 32'd0);
    chk("ram_in",    32'(bus.ram_in),    (acc && m_we) ? 32'(m_wdata) : 32'd0);
  end

  // Ack log for spacing/order checks
  int ack_who[$];
  int ack_cyc[$];
  always @(negedge clk) begin
    if (bus.ack0) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
    if (bus.ack1) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
  end

  // Snapshot of the first cycle after the request is sampled
  logic        snap_en, snap_wr, snap_rd;
  logic [2:0]  snap_add;
  logic [15:0] snap_in;
  logic [1:0]  snap_grant;

  task automatic set_req(input int c, input logic r, input logic we, input logic [2:0] a,
                         input logic [15:0] d);
    if (c == 0) begin bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
  endtask

  // Issue one transaction from IDLE; returns latency in edges and rdata at ack
  task automatic do_req(input int c, input logic we, input logic [2:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd);
    logic got;
    got = 1'b0; lat = 0; rd = 16'h0;
    set_req(c, 1'b1, we, a, d);
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #2;
      if (i == 1) begin
        snap_en = bus.ram_en; snap_wr = bus.ram_write; snap_rd = bus.ram_read;
        snap_add = bus.ram_add; snap_in = bus.ram_in; snap_grant = bus.grant;
      end
      if ((c == 0) ? bus.ack0 : bus.ack1) begin
        got = 1'b1; lat = i; rd = bus.rdata;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    set_req(c, 1'b0, 1'b0, 3'd0, 16'h0);
    @(posedge clk); #2;
  endtask

  int          lat;
  logic [15:0] rd;
  int          n;

  initial begin
    for (int i = 0; i < 8; i++) begin ram_mem[i] = 16'h0; m_mem[i] = 16'h0; end
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // 1: reset mid-transaction with both requests high
    @(posedge clk); #2;
    chk("t1_idle_grant", 32'(bus.grant), 32'd0);
    set_req(0, 1'b1, 1'b0, 3'd1, 16'h0);
    set_req(1, 1'b1, 1'b0, 3'd2, 16'h0);
    @(posedge clk); #2;
    chk("t1_busy_before_rst", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t1_rst_ram_en",   32'(bus.ram_en),   32'd0);
    chk("t1_rst_ram_read", 32'(bus.ram_read), 32'd0);
    chk("t1_rst_grant",    32'(bus.grant),    32'd0);
    chk("t1_rst_busy",     32'(bus.busy),     32'd0);
    chk("t1_rst_acks",     32'({bus.ack1, bus.ack0}), 32'd0);
    bus.req1 = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    do_req(0, 1'b0, 3'd1, 16'h0, lat, rd);
    chk("t1_first_grant", 32'(snap_grant), 32'd1);

    // 2: write then read back through the other client
    do_req(0, 1'b1, 3'd5, 16'hA5A5, lat, rd);
    chk("t2_wr_latency", 32'(lat), 32'd2);
    chk("t2_wr_en",      32'(snap_en), 32'd1);
    chk("t2_wr_write",   32'(snap_wr), 32'd1);
    chk("t2_wr_read",    32'(snap_rd), 32'd0);
    chk("t2_wr_add",     32'(snap_add), 32'd5);
    chk("t2_wr_in",      32'(snap_in), 32'hA5A5);
    do_req(1, 1'b0, 3'd5, 16'h0, lat, rd);
    chk("t2_rd_read",    32'(snap_rd), 32'd1);
    chk("t2_rd_in",      32'(snap_in), 32'd0);
    chk("t2_rd_data",    32'(rd), 32'hA5A5);

    // 3: contention after reset alternates 0,1,0,1 at 3-cycle spacing
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    ack_who.delete(); ack_cyc.delete();
    set_req(0, 1'b1, 1'b0, 3'd5, 16'h0);
    set_req(1, 1'b1, 1'b0, 3'd5, 16'h0);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(posedge clk); #2;
      if (bus.ack0 || bus.ack1) n++;
    end
    set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
    set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
    repeat (2) begin @(posedge clk); #2; end
    chk("t3_ack_count", 32'(ack_who.size()), 32'd4);
    if (ack_who.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_ack_order", 32'(ack_who[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk("t3_ack_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    end

    // 4: client 1 hogs, then client 0 joins and wins next
    ack_who.delete(); ack_cyc.delete();
    set_req(1, 1'b1, 1'b0, 3'd5, 16'h0);
    n = 0;
    for (int i = 0; i < 60 && n < 5; i++) begin
      @(posedge clk); #2;
      if (bus.ack1) n++;
    end
    set_req(0, 1'b1, 1'b0, 3'd0, 16'h0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("t4_c0_wins", 32'(bus.grant), 32'd1);
    @(posedge clk); #2;
    chk("t4_ack0", 32'(bus.ack0), 32'd1);
    set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
    set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
    repeat (2) begin @(posedge clk); #2; end
    chk("t4_ack_count", 32'(ack_who.size()), 32'd6);
    if (ack_who.size() == 6) begin
      for (int i = 0; i < 5; i++) chk("t4_hog_who", 32'(ack_who[i]), 32'd1);
      for (int i = 1; i < 5; i++) chk("t4_hog_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
      chk("t4_last_who", 32'(ack_who[5]), 32'd0);
    end

    // 5: address isolation; writes leave rdata alone
    do_req(0, 1'b1, 3'd0, 16'h0001, lat, rd);
    do_req(1, 1'b1, 3'd7, 16'h8000, lat, rd);
    do_req(0, 1'b1, 3'd2, 16'h1234, lat, rd);
    do_req(1, 1'b0, 3'd0, 16'h0, lat, rd);
    chk("t5_rd_addr0", 32'(rd), 32'h0001);
    do_req(0, 1'b0, 3'd7, 16'h0, lat, rd);
    chk("t5_rd_addr7", 32'(rd), 32'h8000);
    do_req(1, 1'b1, 3'd3, 16'hBEEF, lat, rd);
    chk("t5_wr_keeps_rdata", 32'(rd), 32'h8000);

    // 6: reset during a write access aborts it
    set_req(0, 1'b1, 1'b1, 3'd2, 16'hFFFF);
    @(posedge clk); #2;
    chk("t6_write_strobe", 32'(bus.ram_write), 32'd1);
    #1 rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
    #1;
    chk("t6_write_dropped", 32'(bus.ram_write), 32'd0);
    chk("t6_en_dropped",    32'(bus.ram_en),    32'd0);
    ack_who.delete(); ack_cyc.delete();
    @(posedge clk); #3 rst = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    chk("t6_no_ack", 32'(ack_who.size()), 32'd0);
    do_req(1, 1'b0, 3'd2, 16'h0, lat, rd);
    chk("t6_prior_contents", 32'(rd), 32'h1234);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
